// File: rtl/sccb_slave.sv
`default_nettype none
// ============================================================================
//  Module   : sccb_slave
//  Purpose  : SCCB target. Oversamples SCL/SDA, decodes 3-phase writes and
//             2-phase write + 2-phase read cycles, drives a register port.
//  Revision : 1.0  initial release
// ============================================================================
module sccb_slave #(
    parameter logic [7:0] DEV_ADDR = 8'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_DEV       = 4'd1;
    localparam logic [3:0] c_DEV_ACK   = 4'd2;
    localparam logic [3:0] c_SUB       = 4'd3;
    localparam logic [3:0] c_SUB_ACK   = 4'd4;
    localparam logic [3:0] c_WDATA     = 4'd5;
    localparam logic [3:0] c_WDATA_ACK = 4'd6;
    localparam logic [3:0] c_RDATA     = 4'd7;
    localparam logic [3:0] c_RDATA_ACK = 4'd8;
    localparam logic [3:0] c_IGNORE    = 4'd9;

    logic       r_scl_meta, r_scl_sync, r_scl_dly;
    logic       r_sda_meta, r_sda_sync, r_sda_dly;
    logic [3:0] r_state,    w_state;
    logic [3:0] r_bit_cnt,  w_bit_cnt;
    logic [7:0] r_shift,    w_shift;
    logic       r_sda_oe,   w_sda_oe;
    logic [7:0] r_reg_addr, w_reg_addr;
    logic [7:0] r_reg_wdata, w_reg_wdata;
    logic       r_wr_en,    w_wr_en;
    logic       r_rd_en,    w_rd_en;
    logic       r_rack,     w_rack;

    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_rise = r_scl_sync & ~r_scl_dly;
    assign w_scl_fall = ~r_scl_sync & r_scl_dly;
    assign w_start    = r_scl_sync & r_sda_dly & ~r_sda_sync;
    assign w_stop     = r_scl_sync & ~r_sda_dly & r_sda_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Sync chains reset to the idle-bus level so release makes no edge
            r_scl_meta  <= 1'b1;
            r_scl_sync  <= 1'b1;
            r_scl_dly   <= 1'b1;
            r_sda_meta  <= 1'b1;
            r_sda_sync  <= 1'b1;
            r_sda_dly   <= 1'b1;
            r_state     <= c_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            r_sda_oe    <= 1'b0;
            r_reg_addr  <= 8'h00;
            r_reg_wdata <= 8'h00;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rack      <= 1'b1;
        end else begin
            r_scl_meta  <= scl;
            r_scl_sync  <= r_scl_meta;
            r_scl_dly   <= r_scl_sync;
            r_sda_meta  <= sda_i;
            r_sda_sync  <= r_sda_meta;
            r_sda_dly   <= r_sda_sync;
            r_state     <= w_state;
            r_bit_cnt   <= w_bit_cnt;
            r_shift     <= w_shift;
            r_sda_oe    <= w_sda_oe;
            r_reg_addr  <= w_reg_addr;
            r_reg_wdata <= w_reg_wdata;
            r_wr_en     <= w_wr_en;
            r_rd_en     <= w_rd_en;
            r_rack      <= w_rack;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_bit_cnt   = r_bit_cnt;
        w_shift     = r_shift;
        w_sda_oe    = r_sda_oe;
        w_reg_addr  = r_reg_addr;
        w_reg_wdata = r_reg_wdata;
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_rack      = r_rack;

        if (w_start) begin
            w_state   = c_DEV;
            w_bit_cnt = 4'd0;
            w_sda_oe  = 1'b0;
        end else if (w_stop) begin
            w_state   = c_IDLE;
            w_bit_cnt = 4'd0;
            w_sda_oe  = 1'b0;
        end else if (r_rd_en) begin
            // Register file answers in the clk after the read request
            w_shift   = reg_rdata;
            w_sda_oe  = ~reg_rdata[7];
            w_bit_cnt = 4'd0;
        end else begin
            case (r_state)
                c_DEV, c_SUB, c_WDATA: begin
                    if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                        w_shift   = {r_shift[6:0], r_sda_sync};
                        w_bit_cnt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                        w_bit_cnt = 4'd0;
                        if (r_state == c_DEV) begin
                            if (r_shift[7:1] != DEV_ADDR[7:1]) begin
                                w_state = c_IGNORE;
                            end else begin
                                w_state  = c_DEV_ACK;
                                w_sda_oe = 1'b1;
                            end
                        end else if (r_state == c_SUB) begin
                            w_reg_addr = r_shift;
                            w_state    = c_SUB_ACK;
                            w_sda_oe   = 1'b1;
                        end else begin
                            w_reg_wdata = r_shift;
                            w_wr_en     = 1'b1;
                            w_state     = c_WDATA_ACK;
                            w_sda_oe    = 1'b1;
                        end
                    end
                end
                c_DEV_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = 4'd0;
                        if (r_shift[0]) begin
                            w_state = c_RDATA;
                            w_rd_en = 1'b1;
                        end else begin
                            w_state = c_SUB;
                        end
                    end
                end
                c_SUB_ACK, c_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe  = 1'b0;
                        w_bit_cnt = 4'd0;
                        w_state   = c_WDATA;
                        if (r_state == c_WDATA_ACK) begin
                            w_reg_addr = r_reg_addr + 8'd1;
                        end
                    end
                end
                c_RDATA: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd7) begin
                            w_sda_oe = 1'b0;
                            w_state  = c_RDATA_ACK;
                        end else begin
                            w_shift   = {r_shift[6:0], 1'b0};
                            w_sda_oe  = ~r_shift[6];
                            w_bit_cnt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                c_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_rack = r_sda_sync;
                    end else if (w_scl_fall) begin
                        if (!r_rack) begin
                            w_reg_addr = r_reg_addr + 8'd1;
                            w_rd_en    = 1'b1;
                            w_bit_cnt  = 4'd0;
                            w_state    = c_RDATA;
                        end else begin
                            w_state = c_IGNORE;
                        end
                    end
                end
                c_IDLE, c_IGNORE: begin
                end
                default: begin
                    w_state  = c_IDLE;
                    w_sda_oe = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_reg_addr;
    assign reg_wdata = r_reg_wdata;
    assign reg_wr_en = r_wr_en;
    assign reg_rd_en = r_rd_en;
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire
